// File: rtl/c1_butterfly_stage_pkg.sv
// Shared definitions for the c1 butterfly stage: data widths, the
// sign-magnitude sample type and the zero-normalization helper.
package c1_pkg;

    localparam int          DATA_W  = 12;
    localparam int          MAG_W   = 11;
    localparam logic [10:0] MAG_MAX = 11'd2047;

    // Sign-magnitude sample: sign = 1 means negative.
    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm12_t;

    // Any zero magnitude is emitted as +0, so -0 never leaves the datapath.
    function automatic sm12_t normalize_zero(input sm12_t x);
        return (x.mag == '0) ? sm12_t'('0) : x;
    endfunction

endpackage

// File: rtl/c1_butterfly_stage_if.sv
// Sample bus for the c1 butterfly stage: eight input samples and eight
// registered results. The source side drives samples; the stage side
// returns results.
interface c1_butterfly_stage_if;
    import c1_pkg::*;

    logic [7:0][DATA_W-1:0] i_data;
    logic [7:0][DATA_W-1:0] o_data;

    modport master (output i_data, input  o_data);
    modport slave  (input  i_data, output o_data);

endinterface

// File: rtl/c1_butterfly_stage_sm_addsub.sv
// Combinational sign-magnitude adder/subtractor (sm_addsub).
// Optional feature macro: C1_SAT_EN -- when defined, magnitude overflow
// clamps to 2047; otherwise the magnitude wraps modulo 2048.
module sm_addsub
    import c1_pkg::*;
(
    input  sm12_t i_a,
    input  sm12_t i_b,
    input  logic  i_sub,
    output sm12_t o_y
);

    logic             w_b_sign;
    logic [MAG_W:0]   w_sum;
    logic             w_a_ge_b;
    sm12_t            w_raw;

    // Subtraction is addition with the second operand's sign flipped.
    assign w_b_sign = i_b.sign ^ i_sub;
    assign w_sum    = {1'b0, i_a.mag} + {1'b0, i_b.mag};
    assign w_a_ge_b = (i_a.mag >= i_b.mag);

    // Sign-magnitude add: sum on equal signs, difference toward the larger magnitude otherwise.
    always_comb begin
        // NOTE: default every field first so no path leaves w_raw unassigned (no latch).
        w_raw = '0;
        if (i_a.sign == w_b_sign) begin
            w_raw.sign = i_a.sign;
`ifdef C1_SAT_EN
            w_raw.mag  = w_sum[MAG_W] ? MAG_MAX : w_sum[MAG_W-1:0];
`else
            w_raw.mag  = w_sum[MAG_W-1:0];
`endif
        end else if (w_a_ge_b) begin
            w_raw.sign = i_a.sign;
            w_raw.mag  = i_a.mag - i_b.mag;
        end else begin
            w_raw.sign = w_b_sign;
            w_raw.mag  = i_b.mag - i_a.mag;
        end
    end

    // Equal-magnitude cancellation and wrapped zeros both come out as +0.
    assign o_y = normalize_zero(w_raw);

endmodule

// File: rtl/c1_butterfly_stage.sv
// First butterfly stage of the 8-point transform: Ok = Ik + I(k+4) and
// O(k+4) = Ik - I(k+4) for k = 0..3, registered with one cycle of latency.
// Optional feature macro: C1_SAT_EN (saturating instead of wrapping overflow).
module c1_butterfly_stage
    import c1_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] I0,
    input  logic [DATA_W-1:0] I1,
    input  logic [DATA_W-1:0] I2,
    input  logic [DATA_W-1:0] I3,
    input  logic [DATA_W-1:0] I4,
    input  logic [DATA_W-1:0] I5,
    input  logic [DATA_W-1:0] I6,
    input  logic [DATA_W-1:0] I7,
    output logic [DATA_W-1:0] O0,
    output logic [DATA_W-1:0] O1,
    output logic [DATA_W-1:0] O2,
    output logic [DATA_W-1:0] O3,
    output logic [DATA_W-1:0] O4,
    output logic [DATA_W-1:0] O5,
    output logic [DATA_W-1:0] O6,
    output logic [DATA_W-1:0] O7
);

    sm12_t                  w_in [8];
    logic [7:0][DATA_W-1:0] w_res;
    logic [7:0][DATA_W-1:0] r_out;

    assign w_in[0] = I0;
    assign w_in[1] = I1;
    assign w_in[2] = I2;
    assign w_in[3] = I3;
    assign w_in[4] = I4;
    assign w_in[5] = I5;
    assign w_in[6] = I6;
    assign w_in[7] = I7;

    for (genvar k = 0; k < 4; k++) begin : g_bfly
        sm_addsub u_add (
            .i_a   (w_in[k]),
            .i_b   (w_in[k+4]),
            .i_sub (1'b0),
            .o_y   (w_res[k])
        );
        sm_addsub u_sub (
            .i_a   (w_in[k]),
            .i_b   (w_in[k+4]),
            .i_sub (1'b1),
            .o_y   (w_res[k+4])
        );
    end

    // Output register: reset has priority, otherwise capture a full result set every cycle.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (RESET) r_out <= '0;
        else       r_out <= w_res;
    end

    assign O0 = r_out[0];
    assign O1 = r_out[1];
    assign O2 = r_out[2];
    assign O3 = r_out[3];
    assign O4 = r_out[4];
    assign O5 = r_out[5];
    assign O6 = r_out[6];
    assign O7 = r_out[7];

endmodule

// File: tb/tb_c1_butterfly_stage.sv
// Directed self-checking bench for c1_butterfly_stage.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
module tb_c1_butterfly_stage;
    import c1_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    c1_butterfly_stage_if bus ();

    c1_butterfly_stage dut (
        .CLK   (clk),
        .RESET (rst),
        .I0    (bus.i_data[0]),
        .I1    (bus.i_data[1]),
        .I2    (bus.i_data[2]),
        .I3    (bus.i_data[3]),
        .I4    (bus.i_data[4]),
        .I5    (bus.i_data[5]),
        .I6    (bus.i_data[6]),
        .I7    (bus.i_data[7]),
        .O0    (bus.o_data[0]),
        .O1    (bus.o_data[1]),
        .O2    (bus.o_data[2]),
        .O3    (bus.o_data[3]),
        .O4    (bus.o_data[4]),
        .O5    (bus.o_data[5]),
        .O6    (bus.o_data[6]),
        .O7    (bus.o_data[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a full sample set on the falling edge.
    task automatic drive(input logic [DATA_W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        @(negedge clk);
        bus.i_data[0] = a0; bus.i_data[1] = a1; bus.i_data[2] = a2; bus.i_data[3] = a3;
        bus.i_data[4] = a4; bus.i_data[5] = a5; bus.i_data[6] = a6; bus.i_data[7] = a7;
    endtask

    task automatic edge_and_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0][DATA_W-1:0] exp;
        exp = '0;
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            drive(12'h123, 12'h456, 12'h789, 12'hABC, 12'h321, 12'h654, 12'h987, 12'hCBA);
            edge_and_settle();
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (bus.o_data[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL reset edge%0d O%0d: got %h expected %h", e, k, bus.o_data[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_mixed();
        logic [7:0][DATA_W-1:0] exp;
        exp[0] = 12'd28;  exp[1] = 12'd10;  exp[2] = 12'd8;   exp[3] = 12'h803;
        exp[4] = 12'd16;  exp[5] = 12'h804; exp[6] = 12'h000; exp[7] = 12'h001;
        rst = 1'b0;
        drive(12'd22, 12'd3, 12'd4, 12'h801, 12'd6, 12'd7, 12'd4, 12'h802);
        edge_and_settle();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL mixed O%0d: got %h expected %h", k, bus.o_data[k], exp[k]);
            end
        end
    endtask

    task automatic test_zero_norm();
        logic [7:0][DATA_W-1:0] exp;
        exp    = '0;
        exp[4] = 12'd10;
        drive(12'd5, 12'h800, 12'd0, 12'd0, 12'h805, 12'h800, 12'd0, 12'd0);
        edge_and_settle();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL zero_norm O%0d: got %h expected %h", k, bus.o_data[k], exp[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0][DATA_W-1:0] exp;
        exp = '0;
`ifdef C1_SAT_EN
        exp[0] = 12'h7FF;
`else
        exp[0] = 12'h400;
`endif
        drive(12'h600, 12'd0, 12'd0, 12'd0, 12'h600, 12'd0, 12'd0, 12'd0);
        edge_and_settle();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL overflow O%0d: got %h expected %h", k, bus.o_data[k], exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0][DATA_W-1:0] exp [4];
        logic [7:0][DATA_W-1:0] vec [4];
        for (int v = 0; v < 4; v++) begin
            exp[v] = '0;
            vec[v] = '0;
        end
        // 1 + 2 = 3, 1 - 2 = -1
        vec[0][0] = 12'd1;   vec[0][4] = 12'd2;   exp[0][0] = 12'd3;   exp[0][4] = 12'h801;
        // -5 + 3 = -2, -5 - 3 = -8
        vec[1][1] = 12'h805; vec[1][5] = 12'd3;   exp[1][1] = 12'h802; exp[1][5] = 12'h808;
        // 100 + (-50) = 50, 100 - (-50) = 150
        vec[2][2] = 12'h064; vec[2][6] = 12'h832; exp[2][2] = 12'h032; exp[2][6] = 12'h096;
        // 2047 + 2047 overflows; 2047 - 2047 = +0
        vec[3][3] = 12'h7FF; vec[3][7] = 12'h7FF;
`ifdef C1_SAT_EN
        exp[3][3] = 12'h7FF;
`else
        exp[3][3] = 12'h7FE;
`endif
        for (int v = 0; v < 4; v++) begin
            drive(vec[v][0], vec[v][1], vec[v][2], vec[v][3], vec[v][4], vec[v][5], vec[v][6], vec[v][7]);
            edge_and_settle();
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (bus.o_data[k] !== exp[v][k]) begin
                    errors++;
                    $display("FAIL back_to_back v%0d O%0d: got %h expected %h", v, k, bus.o_data[k], exp[v][k]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0][DATA_W-1:0] exp;
        // Streaming vector before reset: 1 + 2 and 1 - 2.
        exp = '0; exp[0] = 12'd3; exp[4] = 12'h801;
        drive(12'd1, 12'd0, 12'd0, 12'd0, 12'd2, 12'd0, 12'd0, 12'd0);
        edge_and_settle();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL midreset pre O%0d: got %h expected %h", k, bus.o_data[k], exp[k]);
            end
        end
        // Reset edge with live data present.
        exp = '0;
        drive(12'd9, 12'd9, 12'd9, 12'd9, 12'd1, 12'd1, 12'd1, 12'd1);
        rst = 1'b1;
        edge_and_settle();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL midreset rst O%0d: got %h expected %h", k, bus.o_data[k], exp[k]);
            end
        end
        // First edge after reset already carries a valid result.
        exp[0] = 12'd10; exp[1] = 12'd11; exp[2] = 12'd12; exp[3] = 12'd13;
        exp[4] = 12'd8;  exp[5] = 12'd7;  exp[6] = 12'd6;  exp[7] = 12'd5;
        drive(12'd9, 12'd9, 12'd9, 12'd9, 12'd1, 12'd2, 12'd3, 12'd4);
        rst = 1'b0;
        edge_and_settle();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.o_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL midreset post O%0d: got %h expected %h", k, bus.o_data[k], exp[k]);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.i_data  = '0;
        test_reset();
        test_mixed();
        test_zero_norm();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
